// File: rtl/lsu_port_arbiter_if.sv
// lsu_port_arbiter_if: lane request, memory port and response bundle of the LSU port arbiter
interface lsu_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                l0_valid_i, l1_valid_i, l0_ready_o, l1_ready_o;
  logic                l0_we_i, l1_we_i;
  logic [ADDR_W-1:0]   l0_addr_i, l1_addr_i, mem_addr_o;
  logic [DATA_W-1:0]   l0_wdata_i, l1_wdata_i, mem_wdata_o, mem_rdata_i, rsp_rdata_o;
  logic [DATA_W/8-1:0] l0_bmask_i, l1_bmask_i, mem_bmask_o;
  logic                mem_req_o, mem_we_o, rsp0_valid_o, rsp1_valid_o;
  logic [15:0]         conflict_cnt_o;
  modport slave (
    input  l0_valid_i, l1_valid_i, l0_we_i, l1_we_i, l0_addr_i, l1_addr_i,
           l0_wdata_i, l1_wdata_i, l0_bmask_i, l1_bmask_i, mem_rdata_i,
    output l0_ready_o, l1_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
           mem_bmask_o, rsp0_valid_o, rsp1_valid_o, rsp_rdata_o, conflict_cnt_o
  );
  modport master (
    output l0_valid_i, l1_valid_i, l0_we_i, l1_we_i, l0_addr_i, l1_addr_i,
           l0_wdata_i, l1_wdata_i, l0_bmask_i, l1_bmask_i, mem_rdata_i,
    input  l0_ready_o, l1_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
           mem_bmask_o, rsp0_valid_o, rsp1_valid_o, rsp_rdata_o, conflict_cnt_o
  );
endinterface

// File: rtl/lsu_port_arbiter.sv
// lsu_port_arbiter: serialises two LSU lanes (lane 0 oldest) onto one memory/IO port and routes load data back
module lsu_port_arbiter #(
  parameter int          MEM_LAT = 1,
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter logic [15:0] CNT_MAX = 16'hFFFF
) (
  input logic               clk_i,
  input logic               rst_i,
  input logic               flush_i,
  lsu_port_arbiter_if.slave bus
);
  typedef enum logic {IDLE, HOLD1} state_t;
  state_t state, state_nx;
  logic grant0, grant1, dual, sel_we, rsp_hit;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W/8-1:0] sel_bmask;
  logic [MEM_LAT-1:0] tag_v, tag_l;
  logic [15:0] cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      tag_v <= '0;
      tag_l <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      for (int i = MEM_LAT - 1; i > 0; i--) begin
        tag_v[i] <= tag_v[i-1] & ~flush_i;
        tag_l[i] <= tag_l[i-1];
      end
      tag_v[0] <= (grant0 | grant1) & ~sel_we;
      tag_l[0] <= grant1;
      if (dual && cnt != CNT_MAX) cnt <= cnt + 16'd1;
    end
  end
  // HOLD1 reserves the port for the younger lane after a dual request
  always_comb begin
    grant0   = 1'b0;
    grant1   = 1'b0;
    dual     = 1'b0;
    state_nx = IDLE;
    if (!rst_i && !flush_i) begin
      grant0   = state == IDLE && bus.l0_valid_i;
      grant1   = bus.l1_valid_i && (state == HOLD1 || !bus.l0_valid_i);
      dual     = state == IDLE && bus.l0_valid_i && bus.l1_valid_i;
      state_nx = dual ? HOLD1 : IDLE;
    end
  end
  assign sel_we    = grant0 ? bus.l0_we_i    : grant1 & bus.l1_we_i;
  assign sel_addr  = grant0 ? bus.l0_addr_i  : grant1 ? bus.l1_addr_i  : '0;
  assign sel_wdata = grant0 ? bus.l0_wdata_i : grant1 ? bus.l1_wdata_i : '0;
  assign sel_bmask = grant0 ? bus.l0_bmask_i : grant1 ? bus.l1_bmask_i : '0;
  assign bus.l0_ready_o  = grant0;
  assign bus.l1_ready_o  = grant1;
  assign bus.mem_req_o   = grant0 | grant1;
  assign bus.mem_we_o    = sel_we;
  assign bus.mem_addr_o  = sel_addr;
  assign bus.mem_wdata_o = sel_wdata;
  assign bus.mem_bmask_o = sel_bmask;
  // a flush also kills the response arriving in the same cycle
  assign rsp_hit          = tag_v[MEM_LAT-1] & ~flush_i & ~rst_i;
  assign bus.rsp0_valid_o = rsp_hit & ~tag_l[MEM_LAT-1];
  assign bus.rsp1_valid_o = rsp_hit & tag_l[MEM_LAT-1];
  assign bus.rsp_rdata_o  = rsp_hit ? bus.mem_rdata_i : '0;
  assign bus.conflict_cnt_o = cnt;
endmodule

// File: tb/tb_lsu_port_arbiter.sv
// tb_lsu_port_arbiter: directed stimulus shared by four arbiter configurations, checked every cycle
module tb_lsu_port_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, flush, v0, w0, v1, w1;
  logic [31:0] a0, d0, a1, d1;
  logic [3:0] m0, m1;
  logic o_r0[4], o_r1[4], o_req[4], o_we[4], o_rs0[4], o_rs1[4];
  logic [31:0] o_addr[4], o_wd[4], o_rd[4];
  logic [3:0] o_bm[4];
  logic [15:0] o_cnt[4];
  int npass = 0, ntot = 0, cyc = 0;
  bit owe1[4];
  int mcnt[4];
  bit ev[4][8];
  bit el[4][8];
  logic [31:0] ed[4][8];
  logic [31:0] mm[4][256];
  function automatic int lat(input int k);
    return k == 3 ? 1 : k + 1;
  endfunction
  function automatic int cmax(input int k);
    return k == 3 ? 5 : 65535;
  endfunction
  function automatic logic [31:0] init_val(input int i);
    return i == 64 ? 32'hCAFEF00D : 32'h5A5A0000 | i;
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction
  for (genvar g = 0; g < 4; g++) begin : u
    localparam int L = (g == 3) ? 1 : g + 1;
    lsu_port_arbiter_if bus ();
    bit [31:0] em[256];
    bit ew[256];
    bit [31:0] rp[4];
    function automatic logic [31:0] rd_env(input logic [7:0] i);
      return ew[i] ? em[i] : init_val(int'(i));
    endfunction
    assign bus.l0_valid_i = v0;
    assign bus.l0_we_i    = w0;
    assign bus.l0_addr_i  = a0;
    assign bus.l0_wdata_i = d0;
    assign bus.l0_bmask_i = m0;
    assign bus.l1_valid_i = v1;
    assign bus.l1_we_i    = w1;
    assign bus.l1_addr_i  = a1;
    assign bus.l1_wdata_i = d1;
    assign bus.l1_bmask_i = m1;
    assign bus.mem_rdata_i = rp[L-1];
    assign o_r0[g]   = bus.l0_ready_o;
    assign o_r1[g]   = bus.l1_ready_o;
    assign o_req[g]  = bus.mem_req_o;
    assign o_we[g]   = bus.mem_we_o;
    assign o_addr[g] = bus.mem_addr_o;
    assign o_wd[g]   = bus.mem_wdata_o;
    assign o_bm[g]   = bus.mem_bmask_o;
    assign o_rs0[g]  = bus.rsp0_valid_o;
    assign o_rs1[g]  = bus.rsp1_valid_o;
    assign o_rd[g]   = bus.rsp_rdata_o;
    assign o_cnt[g]  = bus.conflict_cnt_o;
    always @(posedge clk) begin
      if (bus.mem_req_o && bus.mem_we_o) begin
        em[bus.mem_addr_o[9:2]] <= merge(rd_env(bus.mem_addr_o[9:2]), bus.mem_wdata_o, bus.mem_bmask_o);
        ew[bus.mem_addr_o[9:2]] <= 1'b1;
      end
      rp[0] <= (bus.mem_req_o && !bus.mem_we_o) ? rd_env(bus.mem_addr_o[9:2]) : 32'h0;
      for (int i = 1; i < 4; i++) rp[i] <= rp[i-1];
    end
    lsu_port_arbiter #(.MEM_LAT(L), .CNT_MAX(g == 3 ? 16'd5 : 16'hFFFF)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(bus)
    );
  end
  task automatic chk(input int k, input string n, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act !== exp) $display("FAIL dut%0d cycle %0d %s: got %0h expected %0h", k, cyc, n, act, exp);
    else npass++;
  endtask
  // expected behaviour: lane 1 is owed the slot after a dual request; loads return lat cycles after issue
  task automatic model_check();
    for (int k = 0; k < 4; k++) begin
      bit live, g0, g1, due, dual, we;
      logic [31:0] ad, wd;
      logic [3:0] bm;
      int s;
      live = !rst && !flush;
      g0 = live && !owe1[k] && v0;
      g1 = live && v1 && (owe1[k] || !v0);
      we = g0 ? w0 : g1 && w1;
      ad = g0 ? a0 : g1 ? a1 : 32'h0;
      wd = g0 ? d0 : g1 ? d1 : 32'h0;
      bm = g0 ? m0 : g1 ? m1 : 4'h0;
      s = cyc % 8;
      due = ev[k][s] && live;
      chk(k, "l0_ready", o_r0[k], g0);
      chk(k, "l1_ready", o_r1[k], g1);
      chk(k, "mem_req", o_req[k], g0 || g1);
      chk(k, "mem_we", o_we[k], we);
      chk(k, "mem_addr", o_addr[k], ad);
      chk(k, "mem_wdata", o_wd[k], wd);
      chk(k, "mem_bmask", o_bm[k], bm);
      chk(k, "rsp0_valid", o_rs0[k], due && !el[k][s]);
      chk(k, "rsp1_valid", o_rs1[k], due && el[k][s]);
      chk(k, "rsp_rdata", o_rd[k], due ? ed[k][s] : 32'h0);
      chk(k, "conflict_cnt", o_cnt[k], 32'(mcnt[k]));
      if (rst) begin
        for (int i = 0; i < 8; i++) ev[k][i] = 1'b0;
        owe1[k] = 1'b0;
        mcnt[k] = 0;
      end else begin
        ev[k][s] = 1'b0;
        if (flush) for (int i = 0; i < 8; i++) ev[k][i] = 1'b0;
        dual = live && !owe1[k] && v0 && v1;
        if (dual && mcnt[k] < cmax(k)) mcnt[k]++;
        owe1[k] = dual;
        if (g0 || g1) begin
          if (we) mm[k][ad[9:2]] = merge(mm[k][ad[9:2]], wd, bm);
          else begin
            s = (cyc + lat(k)) % 8;
            ev[k][s] = 1'b1;
            el[k][s] = g1;
            ed[k][s] = mm[k][ad[9:2]];
          end
        end
      end
    end
    cyc++;
  endtask
  task automatic at_neg();
    @(negedge clk);
    model_check();
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic step();
    at_neg();
    nxt();
  endtask
  task automatic idle();
    flush = 0; v0 = 0; w0 = 0; a0 = 0; d0 = 0; m0 = 0;
    v1 = 0; w1 = 0; a1 = 0; d1 = 0; m1 = 0;
  endtask
  task automatic ld0(input logic [31:0] a);
    v0 = 1; w0 = 0; a0 = a; d0 = 0; m0 = 4'hF;
  endtask
  task automatic st0(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    v0 = 1; w0 = 1; a0 = a; d0 = d; m0 = m;
  endtask
  task automatic ld1(input logic [31:0] a);
    v1 = 1; w1 = 0; a1 = a; d1 = 0; m1 = 4'hF;
  endtask
  initial begin
    for (int k = 0; k < 4; k++) for (int i = 0; i < 256; i++) mm[k][i] = init_val(i);
    idle();
    rst = 1;
    ld0(32'h40);
    nxt();
    at_neg();
    chk(0, "rst_l0_ready", o_r0[0], 0);
    chk(0, "rst_mem_req", o_req[0], 0);
    nxt();
    rst = 0;
    idle();
    at_neg();
    chk(0, "cnt_after_rst", o_cnt[0], 0);
    nxt();
    ld0(32'h100);
    at_neg();
    chk(0, "t1_req", o_req[0], 1);
    chk(0, "t1_addr", o_addr[0], 32'h100);
    nxt();
    idle();
    at_neg();
    chk(0, "t1_rsp0", o_rs0[0], 1);
    chk(0, "t1_rdata", o_rd[0], 32'hCAFEF00D);
    chk(0, "t1_rsp1", o_rs1[0], 0);
    nxt();
    repeat (3) step();
    st0(32'h200, 32'hDEADBEEF, 4'hF);
    ld1(32'h200);
    at_neg();
    chk(0, "t2_l0_ready", o_r0[0], 1);
    chk(0, "t2_l1_wait", o_r1[0], 0);
    chk(0, "t2_store", o_we[0], 1);
    nxt();
    v0 = 0;
    at_neg();
    chk(0, "t2_l1_ready", o_r1[0], 1);
    chk(0, "t2_load_req", o_req[0], 1);
    chk(0, "t2_load_addr", o_addr[0], 32'h200);
    nxt();
    idle();
    at_neg();
    chk(0, "t2_rsp1", o_rs1[0], 1);
    chk(0, "t2_rdata", o_rd[0], 32'hDEADBEEF);
    chk(0, "t2_cnt", o_cnt[0], 1);
    nxt();
    st0(32'h208, 32'h11223344, 4'b0101);
    step();
    ld0(32'h208);
    step();
    idle();
    at_neg();
    chk(0, "bmask_merge", o_rd[0], 32'h5A220044);
    nxt();
    repeat (3) step();
    ld0(32'h300);
    ld1(32'h304);
    step();
    v0 = 0;
    flush = 1;
    at_neg();
    chk(0, "t3_flush_req", o_req[0], 0);
    chk(0, "t3_flush_l1", o_r1[0], 0);
    nxt();
    idle();
    ld0(32'h104);
    at_neg();
    chk(0, "t3_back_idle", o_r0[0], 1);
    chk(0, "t3_no_rsp1", o_rs1[0], 0);
    nxt();
    idle();
    at_neg();
    chk(2, "t3_rsp0_flushed", o_rs0[2], 0);
    chk(2, "t3_no_rsp1", o_rs1[2], 0);
    nxt();
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      ld0(32'(4 * i));
      step();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk(2, "t4_rsp0", o_rs0[2], 1);
      chk(2, "t4_rdata", o_rd[2], 32'h5A5A0000 + 32'(i));
      nxt();
    end
    for (int i = 0; i < 3; i++) begin
      ld0(32'(4 * i));
      step();
    end
    idle();
    at_neg();
    chk(2, "t4f_rsp0_first", o_rs0[2], 1);
    chk(2, "t4f_rdata_first", o_rd[2], 32'h5A5A0000);
    nxt();
    flush = 1;
    at_neg();
    chk(2, "t4f_rsp0_flushed", o_rs0[2], 0);
    nxt();
    flush = 0;
    at_neg();
    chk(2, "t4f_rsp0_dropped", o_rs0[2], 0);
    nxt();
    repeat (2) step();
    ld0(32'h10);
    step();
    rst = 1;
    ld0(32'h14);
    at_neg();
    chk(1, "t5_rst_l0_ready", o_r0[1], 0);
    chk(1, "t5_rst_req", o_req[1], 0);
    nxt();
    rst = 0;
    idle();
    at_neg();
    chk(1, "t5_no_rsp", o_rs0[1], 0);
    chk(1, "t5_cnt", o_cnt[1], 0);
    nxt();
    repeat (2) step();
    ld0(32'h20);
    ld1(32'h24);
    for (int i = 0; i < 20; i++) begin
      at_neg();
      chk(0, "t6_l0_grant", o_r0[0], i % 2 == 0);
      chk(0, "t6_l1_grant", o_r1[0], i % 2 == 1);
      nxt();
    end
    idle();
    at_neg();
    chk(0, "t6_cnt", o_cnt[0], 10);
    chk(3, "t6_cnt_saturated", o_cnt[3], 5);
    nxt();
    repeat (4) step();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
